// File: rtl/sobel_frame_loader.sv
// sobel_frame_loader: packs a raster stream of 8-bit pixels into 64-bit
// SRAM1 words (MSB-first). After a full frame it pulses startEn and waits
// for the filter's getNext before loading the next frame.
// Optional feature: define LOADER_OVERRUN_EN to build the sticky overrun
// detector; otherwise overrun is tied low.
module sobel_frame_loader #(
  parameter int FRAMEWORDS = 32768,
  parameter int BASEADDR   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pixIn,
  input  logic        pixValid,
  output logic        pixReady,
  input  logic        getNext,
  output logic        we1,
  output logic [19:0] write_addr1,
  output logic [63:0] data1,
  output logic        startEn,
  output logic        overrun
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    DONE = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [19:0] LP_BASE = 20'(BASEADDR);
  localparam logic [19:0] LP_LAST = 20'(BASEADDR + FRAMEWORDS - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_pending;
  logic        w_pending_next;
  logic        w_restart;
  logic [2:0]  r_byte_cnt;
  logic [63:0] r_data;
  logic [19:0] r_addr;
  logic        r_we1;
  logic        w_last_write;
  logic        w_accept;

  // The final write of a frame is in flight: stop accepting so no byte of
  // the next frame slips in before the filter has been told.
  assign w_last_write = r_we1 && (r_addr == LP_LAST);
  assign pixReady     = !reset && (r_state == FILL) && !w_last_write;
  assign w_accept     = pixValid && pixReady;

  assign we1         = r_we1;
  assign write_addr1 = r_addr;
  assign data1       = r_data;
  assign startEn     = (r_state == DONE);

  // Next-state, pending-request and address-restart decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    w_state_next   = r_state;
    w_pending_next = r_pending;
    w_restart      = 1'b0;
    case (r_state)
      FILL: begin
        if (getNext)      w_pending_next = 1'b1;
        if (w_last_write) w_state_next   = DONE;
      end
      DONE: begin
        if (r_pending || getNext) begin
          w_state_next   = FILL;
          w_pending_next = 1'b0;
          w_restart      = 1'b1;
        end else begin
          w_state_next   = WAIT;
        end
      end
      WAIT: begin
        if (getNext) begin
          w_state_next = FILL;
          w_restart    = 1'b1;
        end
      end
      default: w_state_next = FILL;
    endcase
  end

  // State register and pending-request flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      r_state   <= FILL;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_pending_next;
    end
  end

  // Byte packing, write strobe and write address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_cnt <= 3'd0;
      r_data     <= 64'd0;
      r_we1      <= 1'b0;
      r_addr     <= LP_BASE;
    end else begin
      r_we1 <= w_accept && (r_byte_cnt == 3'd7);
      if (w_accept) begin
        // Shift-in leaves the first byte of a word in [63:56] after 8 bytes.
        r_data     <= {r_data[55:0], pixIn};
        r_byte_cnt <= r_byte_cnt + 3'd1;
      end
      if (w_restart) begin
        r_addr <= LP_BASE;
      end else if (r_we1) begin
        r_addr <= r_addr + 20'd1;
      end
    end
  end

`ifdef LOADER_OVERRUN_EN
  logic r_overrun;

  // Sticky flag: a byte was offered while the loader could not take it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (pixValid && !pixReady) begin
      r_overrun <= 1'b1;
    end
  end

  assign overrun = r_overrun;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_frame_loader.sv
// tb_sobel_frame_loader: directed bench for sobel_frame_loader with a
// 4-word frame. Inputs change and outputs are sampled on the falling edge.
module tb_sobel_frame_loader;

  localparam int FW = 4;

`ifdef LOADER_OVERRUN_EN
  localparam logic EXP_OVR = 1'b1;
`else
  localparam logic EXP_OVR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pixIn;
  logic        pixValid;
  logic        pixReady;
  logic        getNext;
  logic        we1;
  logic [19:0] write_addr1;
  logic [63:0] data1;
  logic        startEn;
  logic        overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  int not_ready = 0;
  int base_we;
  int base_st;

  int          we_cyc[$];
  logic [19:0] we_addr[$];
  logic [63:0] we_data[$];
  int          st_cyc[$];

  sobel_frame_loader #(.FRAMEWORDS(FW), .BASEADDR(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .pixIn      (pixIn),
    .pixValid   (pixValid),
    .pixReady   (pixReady),
    .getNext    (getNext),
    .we1        (we1),
    .write_addr1(write_addr1),
    .data1      (data1),
    .startEn    (startEn),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and log write strobes and start pulses.
  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    if (we1) begin
      we_cyc.push_back(cyc_n);
      we_addr.push_back(write_addr1);
      we_data.push_back(data1);
    end
    if (startEn) st_cyc.push_back(cyc_n);
  endtask

  // Offer n consecutive bytes first, first+1, ...; getNext rides on byte gn_at.
  task automatic send(input logic [7:0] first, input int n, input int gn_at);
    for (int i = 0; i < n; i++) begin
      pixValid = 1'b1;
      pixIn    = first + 8'(i);
      getNext  = (i == gn_at);
      if (!pixReady) not_ready++;
      cyc();
    end
    pixValid = 1'b0;
    getNext  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pixIn = 8'h00; pixValid = 1'b0; getNext = 1'b0;
    cyc(); cyc();
    check("rst_ready",   64'(pixReady),    64'd0);
    check("rst_we1",     64'(we1),         64'd0);
    check("rst_starten", 64'(startEn),     64'd0);
    check("rst_addr",    64'(write_addr1), 64'd0);
    check("rst_data",    data1,            64'd0);
    check("rst_overrun", 64'(overrun),     64'd0);
    reset = 1'b0;
    cyc();
    check("ready_after_rst", 64'(pixReady), 64'd1);

    // First word of a frame.
    base_we = we_addr.size();
    send(8'h01, 8, -1);
    cyc(); cyc();
    check("w1_count", 64'(we_addr.size() - base_we), 64'd1);
    check("w1_addr",  64'(we_addr[base_we]), 64'd0);
    check("w1_data",  we_data[base_we], 64'h0102030405060708);

    // Reset after a partial word: nothing written, frame restarts at 0.
    base_we = we_addr.size();
    send(8'hA0, 5, -1);
    reset = 1'b1;
    cyc();
    check("prst_ready", 64'(pixReady),    64'd0);
    check("prst_addr",  64'(write_addr1), 64'd0);
    check("prst_data",  data1,            64'd0);
    reset = 1'b0;
    cyc(); cyc();
    check("prst_no_we", 64'(we_addr.size() - base_we), 64'd0);
    send(8'h11, 8, -1);
    cyc();
    check("prst_count", 64'(we_addr.size() - base_we), 64'd1);
    check("prst_waddr", 64'(we_addr[base_we]), 64'd0);
    check("prst_wdata", we_data[base_we], 64'h1112131415161718);

    // Full 4-word frame, back to back.
    reset = 1'b1; cyc(); reset = 1'b0; cyc();
    base_we = we_addr.size();
    base_st = st_cyc.size();
    not_ready = 0;
    send(8'h00, 32, -1);
    cyc();
    check("frm_starten_now", 64'(startEn), 64'd1);
    check("frm_ready_done",  64'(pixReady), 64'd0);
    cyc(); cyc();
    check("frm_ready_wait",  64'(pixReady), 64'd0);
    check("frm_not_ready",   64'(not_ready), 64'd0);
    check("frm_we_count",    64'(we_addr.size() - base_we), 64'd4);
    if (we_addr.size() - base_we == 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("frm_addr%0d", i), 64'(we_addr[base_we + i]), 64'(i));
      for (int i = 1; i < 4; i++) check($sformatf("frm_gap%0d", i), 64'(we_cyc[base_we + i] - we_cyc[base_we + i - 1]), 64'd8);
      check("frm_data0", we_data[base_we],     64'h0001020304050607);
      check("frm_data1", we_data[base_we + 1], 64'h08090A0B0C0D0E0F);
      check("frm_data2", we_data[base_we + 2], 64'h1011121314151617);
      check("frm_data3", we_data[base_we + 3], 64'h18191A1B1C1D1E1F);
      check("frm_st_count", 64'(st_cyc.size() - base_st), 64'd1);
      if (st_cyc.size() - base_st == 1)
        check("frm_st_cycle", 64'(st_cyc[base_st] - we_cyc[base_we + 3]), 64'd1);
    end

    // Byte offered in WAIT: ignored, flags overrun when enabled.
    check("ovr_before", 64'(overrun), 64'd0);
    base_we = we_addr.size();
    pixValid = 1'b1; pixIn = 8'hEE;
    cyc();
    pixValid = 1'b0;
    check("ovr_set", 64'(overrun), 64'(EXP_OVR));
    cyc(); cyc(); cyc();
    check("ovr_hold",    64'(overrun),     64'(EXP_OVR));
    check("ovr_addr",    64'(write_addr1), 64'd4);
    check("ovr_data",    data1,            64'h18191A1B1C1D1E1F);
    check("ovr_no_we",   64'(we_addr.size() - base_we), 64'd0);

    // getNext in WAIT restarts the frame.
    getNext = 1'b1;
    cyc();
    getNext = 1'b0;
    check("gn_ready", 64'(pixReady),    64'd1);
    check("gn_addr",  64'(write_addr1), 64'd0);
    base_we = we_addr.size();
    send(8'h31, 8, -1);
    cyc();
    check("gn_waddr", 64'(we_addr[base_we]), 64'd0);
    check("gn_wdata", we_data[base_we], 64'h3132333435363738);

    // getNext mid-fill: DONE goes straight back to FILL.
    base_we = we_addr.size();
    send(8'h41, 24, 4);
    check("pend_last_addr", 64'(we_addr[we_addr.size() - 1]), 64'd3);
    check("pend_we_count",  64'(we_addr.size() - base_we), 64'd3);
    cyc();
    check("pend_starten", 64'(startEn), 64'd1);
    check("pend_ready_d", 64'(pixReady), 64'd0);
    cyc();
    check("pend_ready_f", 64'(pixReady), 64'd1);
    check("pend_st_off",  64'(startEn),  64'd0);
    base_we = we_addr.size();
    send(8'h51, 8, -1);
    check("pend_next_addr", 64'(we_addr[base_we]), 64'd0);
    send(8'h59, 24, -1);
    cyc(); cyc(); cyc();
    check("pend_cleared", 64'(pixReady), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sobel_frame_loader.md
SOBEL_FRAME_LOADER -- requirements
Module: sobelFrameLoader

Interface
REQ-001 SHALL have parameter FRAMEWORDS, default 32768: 64-bit words per frame (512x512 8-bit pixels).
REQ-002 SHALL have parameter BASEADDR, default 0: SRAM1 word address of the first frame word.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port pixIn, input, 8 bits: incoming pixel byte, raster order.
REQ-006 SHALL have port pixValid, input, 1 bit: pixIn holds a valid byte.
REQ-007 SHALL have port pixReady, output, 1 bit: loader accepts a byte this cycle.
REQ-008 SHALL have port getNext, input, 1 bit: filter request to refill SRAM1.
REQ-009 SHALL have port we1, output, 1 bit: SRAM1 write strobe.
REQ-010 SHALL have port write_addr1, output, 20 bits: SRAM1 write address.
REQ-011 SHALL have port data1, output, 64 bits: SRAM1 write data.
REQ-012 SHALL have port startEn, output, 1 bit: one-cycle pulse telling the filter that a full frame is in SRAM1.
REQ-013 SHALL have port overrun, output, 1 bit: sticky flag for bytes offered while not ready.

Function
REQ-014 SHALL implement states FILL, DONE and WAIT.
REQ-015 A byte SHALL be accepted only in a cycle where pixValid and pixReady are both 1; pixReady SHALL be 1 only in FILL.
REQ-016 Bytes SHALL pack MSB-first: the 1st byte of a word goes to data1[63:56] and the 8th byte to data1[7:0].
REQ-017 A 3-bit byte counter SHALL wrap 7->0 on each completed word.
REQ-018 we1 SHALL be 1 for exactly one cycle, the cycle after the 8th byte is accepted, with data1 and write_addr1 stable in that cycle.
REQ-019 write_addr1 SHALL start at BASEADDR for each frame and increment by 1 after each write; its width is 20 bits and it is never wrapped within a frame.
REQ-020 After the write at BASEADDR+FRAMEWORDS-1, the state SHALL go to DONE. startEn SHALL be 1 in the cycle after that write, and only in that cycle.
REQ-021 DONE SHALL go to WAIT after one cycle. A getNext pulse seen in WAIT SHALL move the state to FILL on the next cycle and reset the address to BASEADDR.
REQ-022 A getNext seen in FILL or DONE SHALL be latched as pending. When DONE is left with a request pending, the state SHALL go straight to FILL, skipping WAIT, and the pending flag SHALL clear.
REQ-023 Bytes accepted while the state is FILL SHALL keep packing with no lost cycle; a byte accepted in the same cycle as a we1 write SHALL begin the next word.
REQ-024 pixValid=1 while pixReady=0 SHALL neither modify data1 nor the address.
REQ-025 With pixValid held at 1, the loader SHALL sustain 1 byte per clock, i.e. one write every 8 cycles.

Reset
REQ-026 While reset=1, the block SHALL set: state=FILL, pixReady=0, we1=0, startEn=0, write_addr1=BASEADDR, data1=0, byte counter=0, pending=0, overrun=0.
REQ-027 pixReady SHALL rise to 1 in the first cycle after reset deasserts, so the first frame loads without getNext.
REQ-028 A reset during a frame SHALL discard the partial word, produce no we1, and restart the frame at BASEADDR.

Configuration
REQ-029 With macro LOADER_OVERRUN_EN defined, overrun SHALL be set the cycle after any cycle with pixValid=1 and pixReady=0, and SHALL hold until reset.
REQ-030 With LOADER_OVERRUN_EN undefined, overrun SHALL be tied to 0 and no detection logic SHALL be built.

Verification
REQ-031 Bench SHALL cover: 8 bytes 0x01..0x08 after reset -> one we1 pulse, write_addr1=0, data1=0x0102030405060708.
REQ-032 Bench SHALL cover: FRAMEWORDS=4, 32 back-to-back bytes -> we1 at addresses 0..3 spaced 8 cycles apart, startEn pulsed once the cycle after the address-3 write, pixReady=0 afterwards.
REQ-033 Bench SHALL cover: in WAIT, pulse getNext -> pixReady=1 on the next cycle, next write at address 0.
REQ-034 Bench SHALL cover: getNext pulsed mid-fill -> after startEn, the state skips WAIT and pixReady=1 one cycle after DONE.
REQ-035 Bench SHALL cover: reset asserted after 5 bytes -> no we1; the next 8 bytes write address 0.
REQ-036 Bench SHALL cover: with LOADER_OVERRUN_EN, pixValid=1 in WAIT -> overrun=1 next cycle and it stays 1; without the macro, overrun stays 0.
